mult_stream_adapter: RTL and testbench
======================================

// Module: mult_stream_adapter
// PURPOSE
//  Upstream driver/consumer for the vdic_dut_2023 signed multiplier. Takes operand
//  pairs on a valid/ready stream, computes even parity, drives the DUT req/ack
//  handshake, and captures result/result_rdy with parity checks. Returns one status-
//  tagged result per operand pair on a valid/ready output stream. One op in flight.
// PARAMETERS
//  DATA_W          16   operand width; result width is 2*DATA_W
//  TIMEOUT_CYCLES  255  max cycles in REQ+WAIT_RES before abort; 0 disables timeout
// PORTS
//  clk                  in   1         clock, rising edge
//  rst_n                in   1         async active-low reset
//  in_valid             in   1         operand pair valid
//  in_ready             out  1         adapter can accept a pair
//  in_a / in_b          in   DATA_W    signed operands
//  in_corrupt_a/_b      in   1         invert generated parity of a/b (error injection)
//  dut_arg_a/_b         out  DATA_W    operands to DUT
//  dut_arg_a/_b_parity  out  1         even parity to DUT (^arg, XOR-inverted if corrupt)
//  dut_req              out  1         request to DUT
//  dut_ack              in   1         DUT accepted args (1-cycle pulse)
//  dut_result           in   2*DATA_W  DUT product, valid when dut_result_rdy=1
//  dut_result_parity    in   1         DUT result parity
//  dut_result_rdy       in   1         DUT result valid (1-cycle pulse)
//  dut_arg_parity_error in   1         DUT arg-parity flag, sampled with dut_result_rdy
//  out_valid            out  1         result record valid
//  out_ready            in   1         downstream accepts record
//  out_result           out  2*DATA_W  captured product (0 on timeout)
//  out_arg_err          out  1         DUT reported arg parity error
//  out_res_perr         out  1         ^dut_result != dut_result_parity
//  out_timeout          out  1         op aborted by timeout
//  busy                 out  1         state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, all other outputs 0, timeout counter
//   0. Reset mid-op drops dut_req immediately; the in-flight op is discarded.
//  FSM IDLE -> REQ -> WAIT_RES -> OUT -> IDLE. All DUT-side and out_* outputs are registered.
//  IDLE: in_ready=1. On in_valid: register a, b and both parities, then go to REQ.
//  REQ: dut_req=1; dut_arg_* stay stable until ack. Counter clears on entry to REQ.
//   On dut_ack: go to WAIT_RES, and dut_req is 0 in the next cycle.
//   If dut_ack and dut_result_rdy arrive in the same cycle: capture and go to OUT.
//  WAIT_RES: dut_req=0. On dut_result_rdy: capture result, arg_err and res_perr,
//   then go to OUT.
//  Timeout: the counter increments each cycle in REQ/WAIT_RES. When TIMEOUT_CYCLES
//   cycles elapse with no completion, go to OUT with out_timeout=1, out_result=0 and
//   other flags 0. A completion in the same cycle as expiry wins; no timeout is reported.
//  OUT: out_valid=1; out_* hold stable while out_ready=0. On out_ready: go to IDLE,
//   out_valid=0 next cycle.
//  Latency: accept at T -> dut_req=1 at T+1. rdy at R -> out_valid=1 at R+1.
//   With out_ready=1, the minimum back-to-back period is 4 cycles plus DUT latency.
//  dut_ack or dut_result_rdy seen in IDLE or OUT is ignored; state is unchanged.
//  Parity is even: parity bit = XOR of all bits. in_corrupt_* is sampled at accept only.
//  Product is signed DATA_W x DATA_W -> 2*DATA_W. The adapter passes it through unmodified.
// TESTING
//  1. a=3,b=-2 (0xFFFE); ack @+2, rdy @+3, result 0xFFFFFFFA, parity 0 -> arg_a_par=0,
//     arg_b_par=1, out_result=0xFFFFFFFA, all flags 0.
//  2. a=b=0x8000 -> both arg parities 1; DUT returns 0x40000000, par 1
//     -> out_result=0x40000000, flags 0.
//  3. a=1, in_corrupt_a=1 -> dut_arg_a_parity=0; DUT returns arg_parity_error=1,
//     result 0 -> out_arg_err=1.
//  4. DUT returns result=0x00000001 with result_parity=0 -> out_res_perr=1,
//     out_result=1.
//  5. TIMEOUT_CYCLES=8, ack never given -> dut_req high exactly 8 cycles,
//     out_valid=1, out_timeout=1, out_result=0.
//  6. out_ready=0 for 5 cycles: out_* stable, in_ready=0, in_valid ignored.
//     Then rst_n=0 mid-REQ: dut_req=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/mult_stream_adapter.sv
// Stream front-end for the vdic signed multiplier: one op in flight,
// parity generation/checking and a status-tagged result record.
module mult_stream_adapter #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  input  logic                  in_corrupt_a,
  input  logic                  in_corrupt_b,
  output logic [DATA_W-1:0]     dut_arg_a,
  output logic [DATA_W-1:0]     dut_arg_b,
  output logic                  dut_arg_a_parity,
  output logic                  dut_arg_b_parity,
  output logic                  dut_req,
  input  logic                  dut_ack,
  input  logic [2*DATA_W-1:0]   dut_result,
  input  logic                  dut_result_parity,
  input  logic                  dut_result_rdy,
  input  logic                  dut_arg_parity_error,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_result,
  output logic                  out_arg_err,
  output logic                  out_res_perr,
  output logic                  out_timeout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RES,
    OUT
  } state_t;

  localparam int CNT_W =
    (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t state_nxt;
  logic [CNT_W-1:0] cnt;
  logic accept;
  logic capture;
  logic abort;
  logic expire;

  assign expire   = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // ack alone is not a completion, so expiry still aborts
        if (dut_ack && dut_result_rdy) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = OUT;
        end else if (dut_ack) begin
          state_nxt = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (dut_result_rdy) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == REQ || state == WAIT_RES) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_arg_a        <= '0;
      dut_arg_b        <= '0;
      dut_arg_a_parity <= 1'b0;
      dut_arg_b_parity <= 1'b0;
    end else if (accept) begin
      dut_arg_a        <= in_a;
      dut_arg_b        <= in_b;
      dut_arg_a_parity <= (^in_a) ^ in_corrupt_a;
      dut_arg_b_parity <= (^in_b) ^ in_corrupt_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_req   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      dut_req   <= (state_nxt == REQ);
      out_valid <= (state_nxt == OUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result   <= '0;
      out_arg_err  <= 1'b0;
      out_res_perr <= 1'b0;
      out_timeout  <= 1'b0;
    end else if (capture) begin
      out_result   <= dut_result;
      out_arg_err  <= dut_arg_parity_error;
      out_res_perr <= (^dut_result) ^ dut_result_parity;
      out_timeout  <= 1'b0;
    end else if (abort) begin
      out_result   <= '0;
      out_arg_err  <= 1'b0;
      out_res_perr <= 1'b0;
      out_timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_stream_adapter.sv
// Bench for mult_stream_adapter: directed cases plus random ops
// against a behavioural multiplier responder and record model.
module tb_mult_stream_adapter;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_corrupt_a;
  logic        in_corrupt_b;
  logic [15:0] dut_arg_a;
  logic [15:0] dut_arg_b;
  logic        dut_arg_a_parity;
  logic        dut_arg_b_parity;
  logic        dut_req;
  logic        dut_ack;
  logic [31:0] dut_result;
  logic        dut_result_parity;
  logic        dut_result_rdy;
  logic        dut_arg_parity_error;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_arg_err;
  logic        out_res_perr;
  logic        out_timeout;
  logic        busy;

  int n_chk;
  int n_fail;

  mult_stream_adapter #(
    .DATA_W(16),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_corrupt_a(in_corrupt_a),
    .in_corrupt_b(in_corrupt_b),
    .dut_arg_a(dut_arg_a),
    .dut_arg_b(dut_arg_b),
    .dut_arg_a_parity(dut_arg_a_parity),
    .dut_arg_b_parity(dut_arg_b_parity),
    .dut_req(dut_req),
    .dut_ack(dut_ack),
    .dut_result(dut_result),
    .dut_result_parity(dut_result_parity),
    .dut_result_rdy(dut_result_rdy),
    .dut_arg_parity_error(dut_arg_parity_error),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_arg_err(out_arg_err),
    .out_res_perr(out_res_perr),
    .out_timeout(out_timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Behavioural multiplier: answers from the args it was handed
  task automatic respond(input logic res_bad);
    logic [31:0] p;
    p = 32'(longint'($signed(dut_arg_a)) *
            longint'($signed(dut_arg_b)));
    dut_result           = p;
    dut_result_parity    = (^p) ^ res_bad;
    dut_arg_parity_error =
      ((^dut_arg_a) != dut_arg_a_parity) ||
      ((^dut_arg_b) != dut_arg_b_parity);
    dut_result_rdy       = 1'b1;
  endtask

  // ack_cyc: REQ cycle (1-based) carrying ack, 0 = never.
  // rdy_dly: cycles from ack to result_rdy (0 = same cycle).
  task automatic run_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic ca,
                        input logic cb,
                        input logic res_bad,
                        input int ack_cyc,
                        input int rdy_dly,
                        input int stall);
    logic [31:0] e_res;
    logic e_to;
    logic e_ae;
    logic e_pe;
    int rdy_i;
    int req_cnt;
    int seen_i;
    e_to = (ack_cyc == 0) || (ack_cyc + rdy_dly > TO);
    e_res = e_to ? 32'd0 :
      32'(longint'($signed(a)) * longint'($signed(b)));
    e_ae = !e_to && (ca || cb);
    e_pe = !e_to && res_bad;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid     = 1'b1;
    in_a         = a;
    in_b         = b;
    in_corrupt_a = ca;
    in_corrupt_b = cb;
    @(negedge clk);
    in_valid     = 1'b0;
    in_corrupt_a = 1'b0;
    in_corrupt_b = 1'b0;
    chk("req_lat", dut_req, 1);
    chk("arg_a", dut_arg_a, a);
    chk("arg_b", dut_arg_b, b);
    chk("par_a", dut_arg_a_parity, (^a) ^ ca);
    chk("par_b", dut_arg_b_parity, (^b) ^ cb);
    rdy_i   = ack_cyc + rdy_dly;
    req_cnt = 0;
    seen_i  = 0;
    for (int i = 1; i <= 40 && seen_i == 0; i++) begin
      if (i > 1) @(negedge clk);
      dut_ack        = 1'b0;
      dut_result_rdy = 1'b0;
      if (out_valid) begin
        seen_i = i;
      end else begin
        if (dut_req) req_cnt++;
        if (ack_cyc != 0 && i == ack_cyc) dut_ack = 1'b1;
        if (ack_cyc != 0 && i == rdy_i) respond(res_bad);
      end
    end
    chk("out_lat", seen_i, e_to ? TO + 1 : rdy_i + 1);
    chk("req_len", req_cnt, (ack_cyc == 0) ? TO : ack_cyc);
    chk("out_result", out_result, e_res);
    chk("out_arg_err", out_arg_err, e_ae);
    chk("out_res_perr", out_res_perr, e_pe);
    chk("out_timeout", out_timeout, e_to);
    for (int s = 0; s < stall; s++) begin
      in_valid       = 1'b1;
      in_a           = 16'($urandom);
      dut_ack        = 1'b1;
      dut_result_rdy = 1'b1;
      dut_result     = 32'($urandom);
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_result", out_result, e_res);
      chk("stall_to", out_timeout, e_to);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_req", dut_req, 0);
    end
    in_valid       = 1'b0;
    dut_ack        = 1'b0;
    dut_result_rdy = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_valid", out_valid, 0);
    chk("pop_in_ready", in_ready, 1);
  endtask

  initial begin
    n_chk                = 0;
    n_fail               = 0;
    rst_n                = 1'b0;
    in_valid             = 1'b0;
    in_a                 = '0;
    in_b                 = '0;
    in_corrupt_a         = 1'b0;
    in_corrupt_b         = 1'b0;
    dut_ack              = 1'b0;
    dut_result           = '0;
    dut_result_parity    = 1'b0;
    dut_result_rdy       = 1'b0;
    dut_arg_parity_error = 1'b0;
    out_ready            = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req", dut_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", out_result, 0);
    chk("rst_arg_a", dut_arg_a, 0);
    rst_n = 1'b1;

    run_op(16'd3, 16'hFFFE, 0, 0, 0, 2, 1, 0);
    run_op(16'h8000, 16'h8000, 0, 0, 0, 1, 2, 0);
    run_op(16'd1, 16'd0, 1, 0, 0, 1, 1, 0);
    run_op(16'd1, 16'd1, 0, 0, 1, 3, 0, 0);
    run_op(16'h1234, 16'h0042, 0, 0, 0, 0, 0, 0);
    run_op(16'h7FFF, 16'h8001, 0, 0, 0, 1, 7, 0);
    run_op(16'h0005, 16'hFFFB, 0, 0, 0, 1, 8, 0);
    run_op(16'hFFFF, 16'hFFFF, 0, 1, 0, 2, 2, 5);

    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), 16'($urandom),
             ($urandom_range(3) == 0),
             ($urandom_range(3) == 0),
             ($urandom_range(3) == 0),
             $urandom_range(4, 1),
             $urandom_range(3),
             $urandom_range(3));
    end

    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'h00AA;
    in_b     = 16'h0055;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_req", dut_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_req", dut_req, 0);
    chk("async_busy", busy, 0);
    chk("async_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_req", dut_req, 0);
    run_op(16'hFFF0, 16'd16, 0, 0, 0, 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
